// File: rtl/padd_pkg.sv
// Shared definitions for the pipelined adder: slice sizing, config check, mode encoding.
package padd_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages > 0) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/padd_stage.sv
// One SLICE-bit adder slice with registered valid, sum and carry-out.
// With PADD_OVERFLOW_EN defined it also registers signed overflow of its slice.
module padd_stage #(
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vin,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic             vld_q,
  output logic [SLICE-1:0] sum_q,
  output logic             co_q
`ifdef PADD_OVERFLOW_EN
  ,
  output logic             ovf_q
`endif
);

  logic [SLICE:0] s;

  assign s = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sum_q <= '0;
      co_q  <= 1'b0;
`ifdef PADD_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else if (en) begin
      vld_q <= vin;
      sum_q <= s[SLICE-1:0];
      co_q  <= s[SLICE];
`ifdef PADD_OVERFLOW_EN
      // carry into the MSB recovered from the MSB sum bit, xor carry out
      ovf_q <= a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1] ^ s[SLICE];
`endif
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides, one slice per stage.
// Optional `overflow` output (signed overflow) when PADD_OVERFLOW_EN is defined.
module pipelined_adder
  import padd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef PADD_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              advance;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] co_pipe;
  logic [WIDTH-1:0]  bx;
  logic              c0;
`ifdef PADD_OVERFLOW_EN
  logic [STAGES-1:0] ovf_pipe;
`endif

  // every stage moves together; a stalled output freezes the whole pipe
  assign advance     = !out_valid || out_ready;
  assign in_ready    = advance;
  assign vld_pipe[0] = in_valid;
  assign bx          = (sub == MODE_SUB) ? ~operand2 : operand2;
  assign c0          = (sub == MODE_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // a_rem/b_rem: operand bits not yet added, slice k in the low bits
    logic [WIDTH-k*SLICE-1:0] a_rem;
    logic [WIDTH-k*SLICE-1:0] b_rem;
    logic [SLICE-1:0]         sum_q;
    logic [(k+1)*SLICE-1:0]   res;
    logic                     ci;

    if (k == 0) begin : g_first
      assign a_rem = operand1;
      assign b_rem = bx;
      assign ci    = c0;
      assign res   = sum_q;
    end else begin : g_rest
      logic [k*SLICE-1:0] lo_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          a_rem <= '0;
          b_rem <= '0;
          lo_q  <= '0;
        end else if (advance) begin
          a_rem <= g_st[k-1].a_rem[WIDTH-(k-1)*SLICE-1:SLICE];
          b_rem <= g_st[k-1].b_rem[WIDTH-(k-1)*SLICE-1:SLICE];
          lo_q  <= g_st[k-1].res;
        end
      end

      assign ci  = co_pipe[k-1];
      assign res = {sum_q, lo_q};
    end

    padd_stage #(.SLICE(SLICE)) u_stage (
      .clk   (clk),
      .rst_n (resetn),
      .en    (advance),
      .vin   (vld_pipe[k]),
      .a     (a_rem[SLICE-1:0]),
      .b     (b_rem[SLICE-1:0]),
      .ci    (ci),
      .vld_q (vld_pipe[k+1]),
      .sum_q (sum_q),
      .co_q  (co_pipe[k])
`ifdef PADD_OVERFLOW_EN
      ,
      .ovf_q (ovf_pipe[k])
`endif
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign result    = g_st[STAGES-1].res;
  assign cout      = co_pipe[STAGES-1];
`ifdef PADD_OVERFLOW_EN
  assign overflow  = ovf_pipe[STAGES-1];
`endif

endmodule
